// File: rtl/hamming_pkg.sv
// Shared constants for the 32-bit extended Hamming checker: code geometry,
// parity slot positions and the data-bit to codeword-bit map.
package hamming_pkg;

    localparam int CODE_W = 32;
    localparam int DATA_W = 26;
    localparam int SYN_W  = 5;

    // Index 5 is the overall-parity bit
    localparam logic [4:0] PARITY_POS [6] = '{5'd0, 5'd1, 5'd3, 5'd7, 5'd15, 5'd31};

    localparam logic [4:0] DATA_MAP [DATA_W] = '{
        5'd2,  5'd4,  5'd5,  5'd6,  5'd8,  5'd9,  5'd10, 5'd11, 5'd12,
        5'd13, 5'd14, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22,
        5'd23, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30
    };

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] d;
        for (int j = 0; j < DATA_W; j++) begin
            d[j] = code[DATA_MAP[j]];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_checker_if.sv
// Valid/ready stream bundle for the Hamming checker: codeword in, decoded result out.
interface hamming_checker_if;
    import hamming_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [CODE_W-1:0]   in_code;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                out_single;
    logic                out_double;
    logic [SYN_W-1:0]    out_syndrome;

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_single, out_double, out_syndrome
    );

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_single, out_double, out_syndrome
    );

endinterface

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity evaluation of one 32-bit codeword.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic [SYN_W-1:0]  o_syndrome,
    output logic              o_parity_fail
);

    // Bit i sits at Hamming position i+1; it feeds every syndrome bit set in that position
    always_comb begin
        o_syndrome = '0;
        for (int i = 0; i < CODE_W - 1; i++) begin
            for (int k = 0; k < SYN_W; k++) begin
                if ((((i + 1) >> k) & 1) != 0) begin
                    o_syndrome[k] = o_syndrome[k] ^ i_code[i];
                end
            end
        end
        o_parity_fail = ^i_code;
    end

endmodule

// File: rtl/hamming_checker.sv
// Two-stage SECDED checker: stage 1 holds codeword+syndrome, stage 2 holds the
// corrected data and flags; saturating counters tally delivered error results.
module hamming_checker
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    hamming_checker_if.slave    bus,
    input  logic                cnt_clear,
    output logic [CNT_W-1:0]    single_cnt,
    output logic [CNT_W-1:0]    double_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [SYN_W-1:0]  w_syn_p0;
    logic              w_pf_p0;

    logic              r_vld_p1;
    logic [CODE_W-1:0] r_code_p1;
    logic [SYN_W-1:0]  r_syn_p1;
    logic              r_pf_p1;

    logic              r_vld_p2;
    logic [DATA_W-1:0] r_data_p2;
    logic              r_single_p2;
    logic              r_double_p2;
    logic [SYN_W-1:0]  r_syn_p2;

    logic [CNT_W-1:0]  r_single_cnt;
    logic [CNT_W-1:0]  r_double_cnt;

    logic              w_s2_ready;
    logic              w_s1_ready;
    logic              w_out_fire;
    logic [4:0]        w_fix_idx;
    logic [CODE_W-1:0] w_fixed_p1;

    hamming_syndrome u_syndrome (
        .i_code        (bus.in_code),
        .o_syndrome    (w_syn_p0),
        .o_parity_fail (w_pf_p0)
    );

    assign w_s2_ready   = !r_vld_p2 || bus.out_ready;
    assign w_s1_ready   = !r_vld_p1 || w_s2_ready;
    assign w_out_fire   = r_vld_p2 && bus.out_ready;
    // Reset gating keeps the block from advertising space while held in reset
    assign bus.in_ready = reset && w_s1_ready;

    // ---- stage 0 -> stage 1
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vld_p1 <= 1'b0;
        end else if (w_s1_ready) begin
            r_vld_p1 <= bus.in_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (w_s1_ready && bus.in_valid) begin
            r_code_p1 <= bus.in_code;
            r_syn_p1  <= w_syn_p0;
            r_pf_p1   <= w_pf_p0;
        end
    end

    // Syndrome 0 with a parity failure points at the overall-parity bit itself
    assign w_fix_idx  = (r_syn_p1 == 5'd0) ? PARITY_POS[5] : r_syn_p1 - 5'd1;
    assign w_fixed_p1 = r_code_p1 ^ (r_pf_p1 ? (32'd1 << w_fix_idx) : 32'd0);

    // ---- stage 1 -> stage 2
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vld_p2    <= 1'b0;
            r_data_p2   <= '0;
            r_single_p2 <= 1'b0;
            r_double_p2 <= 1'b0;
            r_syn_p2    <= '0;
        end else if (w_s2_ready) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2   <= extract_data(w_fixed_p1);
                r_single_p2 <= r_pf_p1;
                r_double_p2 <= !r_pf_p1 && (r_syn_p1 != 5'd0);
                r_syn_p2    <= r_syn_p1;
            end
        end
    end

    // ---- delivered-result counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_single_cnt <= '0;
            r_double_cnt <= '0;
        end else if (cnt_clear) begin
            r_single_cnt <= '0;
            r_double_cnt <= '0;
        end else if (w_out_fire) begin
            if (r_single_p2) r_single_cnt <= sat_inc(r_single_cnt);
            if (r_double_p2) r_double_cnt <= sat_inc(r_double_cnt);
        end
    end

    assign bus.out_valid    = r_vld_p2;
    assign bus.out_data     = r_data_p2;
    assign bus.out_single   = r_single_p2;
    assign bus.out_double   = r_double_p2;
    assign bus.out_syndrome = r_syn_p2;
    assign single_cnt       = r_single_cnt;
    assign double_cnt       = r_double_cnt;

endmodule

// File: tb/tb_hamming_checker.sv
// Randomized bench for hamming_checker: a positional Hamming decoder and an
// occupancy/latency model predict every output on every cycle.
module tb_hamming_checker;

    localparam int TB_CNT_W = 2;
    localparam logic [TB_CNT_W-1:0] CNT_MAX = '1;

    typedef struct {
        logic [25:0] data;
        logic        single;
        logic        dbl;
        logic [4:0]  syn;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cnt_clear = 1'b0;
    logic [TB_CNT_W-1:0] single_cnt;
    logic [TB_CNT_W-1:0] double_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [31:0] tx_q[$];
    exp_t        exp_q[$];
    logic [TB_CNT_W-1:0] m_single = '0;
    logic [TB_CNT_W-1:0] m_double = '0;

    hamming_checker_if hif ();

    hamming_checker #(.CNT_W(TB_CNT_W)) dut (
        .clock      (clk),
        .reset      (rst_n),
        .bus        (hif),
        .cnt_clear  (cnt_clear),
        .single_cnt (single_cnt),
        .double_cnt (double_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decode by position arithmetic: syndrome = XOR of positions of set bits
    function automatic exp_t ref_decode(input logic [31:0] c_in);
        exp_t r;
        logic [31:0] c;
        logic pf;
        int j;
        c = c_in;
        r.syn = '0;
        for (int p = 1; p <= 31; p++) if (c[p-1]) r.syn ^= 5'(p);
        pf = ^c;
        r.single = pf;
        r.dbl = !pf && (r.syn != 5'd0);
        if (pf) begin
            if (r.syn == 5'd0) c[31] = ~c[31];
            else c[r.syn - 1] = ~c[r.syn - 1];
        end
        r.data = '0;
        j = 0;
        for (int p = 1; p <= 31; p++) begin
            if ((p & (p - 1)) != 0) begin
                r.data[j] = c[p-1];
                j++;
            end
        end
        r.acc = 0;
        return r;
    endfunction

    function automatic logic [31:0] encode(input logic [25:0] d);
        logic [31:0] c;
        logic [4:0] s;
        int j;
        c = '0;
        s = '0;
        j = 0;
        for (int p = 1; p <= 31; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[j];
                j++;
            end
        end
        for (int p = 1; p <= 31; p++) if (c[p-1]) s ^= 5'(p);
        for (int k = 0; k < 5; k++) if (s[k]) c[(1 << k) - 1] = 1'b1;
        c[31] = ^c[30:0];
        return c;
    endfunction

    function automatic logic [31:0] mk_word(input int nerr);
        logic [31:0] c;
        int a;
        int b;
        c = encode(26'($urandom()));
        a = $urandom_range(0, 31);
        b = (a + $urandom_range(1, 31)) % 32;
        if (nerr >= 1) c[a] = ~c[a];
        if (nerr == 2) c[b] = ~c[b];
        return c;
    endfunction

    // Compare process: sample 1ns before each rising edge
    initial begin
        exp_t e;
        int n;
        logic exp_ov;
        logic fire;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (!rst_n) begin
                chk("rst_in_ready", hif.in_ready, 0);
                chk("rst_out_valid", hif.out_valid, 0);
                chk("rst_out_data", hif.out_data, 0);
                chk("rst_out_single", hif.out_single, 0);
                chk("rst_out_double", hif.out_double, 0);
                chk("rst_out_syndrome", hif.out_syndrome, 0);
                chk("rst_single_cnt", single_cnt, 0);
                chk("rst_double_cnt", double_cnt, 0);
                exp_q.delete();
                m_single = '0;
                m_double = '0;
            end else begin
                n = exp_q.size();
                chk("in_ready", hif.in_ready, (n < 2) || hif.out_ready);
                exp_ov = (n > 0) && (cyc >= exp_q[0].acc + 2);
                chk("out_valid", hif.out_valid, exp_ov);
                chk("flags_exclusive", hif.out_single & hif.out_double, 0);
                chk("single_cnt", single_cnt, m_single);
                chk("double_cnt", double_cnt, m_double);
                if (hif.out_valid && n > 0) begin
                    chk("out_data", hif.out_data, exp_q[0].data);
                    chk("out_single", hif.out_single, exp_q[0].single);
                    chk("out_double", hif.out_double, exp_q[0].dbl);
                    chk("out_syndrome", hif.out_syndrome, exp_q[0].syn);
                end
                fire = exp_ov && hif.out_ready;
                if (cnt_clear) begin
                    m_single = '0;
                    m_double = '0;
                end else if (fire) begin
                    if (exp_q[0].single && m_single != CNT_MAX) m_single++;
                    if (exp_q[0].dbl && m_double != CNT_MAX) m_double++;
                end
                if (fire) void'(exp_q.pop_front());
                if (hif.in_valid && hif.in_ready) begin
                    e = ref_decode(hif.in_code);
                    e.acc = cyc;
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic cycle(input logic ivok, input logic ordy, input logic clr);
        @(negedge clk);
        hif.in_valid  = ivok && (tx_q.size() > 0);
        hif.in_code   = hif.in_valid ? tx_q[0] : $urandom();
        hif.out_ready = ordy;
        cnt_clear     = clr;
        #4;
        if (hif.in_valid && hif.in_ready) void'(tx_q.pop_front());
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (tx_q.size() > 0 || exp_q.size() > 0); i++) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("drain_bound", tx_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        exp_t r;
        logic hit;
        hif.in_valid = 1'b0;
        hif.in_code = '0;
        hif.out_ready = 1'b1;

        // Pin the reference model against hand-decoded words
        r = ref_decode(32'h80000007);
        chk("pin_clean", {r.data, r.single, r.dbl, r.syn}, {26'h1, 1'b0, 1'b0, 5'd0});
        r = ref_decode(32'h80000407);
        chk("pin_single11", {r.data, r.single, r.dbl, r.syn}, {26'h1, 1'b1, 1'b0, 5'd11});
        r = ref_decode(32'h80000004);
        chk("pin_double3", {r.data, r.single, r.dbl, r.syn}, {26'h1, 1'b0, 1'b1, 5'd3});
        r = ref_decode(32'h00000007);
        chk("pin_single_p31", {r.data, r.single, r.dbl, r.syn}, {26'h1, 1'b1, 1'b0, 5'd0});
        chk("pin_encode", encode(26'h1), 32'h80000007);

        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        chk("in_ready_after_rst", hif.in_ready, 1);

        // Directed vectors
        tx_q.push_back(32'h80000007);
        tx_q.push_back(32'h80000407);
        tx_q.push_back(32'h80000004);
        tx_q.push_back(32'h00000007);
        drain();
        chk("dir_single_cnt", single_cnt, 2);
        chk("dir_double_cnt", double_cnt, 1);

        // Back-pressure: two words fill the pipe, the rest wait
        for (int i = 0; i < 5; i++) tx_q.push_back(mk_word(i % 3));
        cycle(1'b1, 1'b1, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        chk("stall_in_ready", hif.in_ready, 0);
        chk("stall_accepted", tx_q.size(), 3);
        drain();

        // Saturation at CNT_W=2, then clear racing a delivered single
        cycle(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) tx_q.push_back(mk_word(1));
        drain();
        chk("sat_single_cnt", single_cnt, 3);
        tx_q.push_back(mk_word(1));
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            hif.in_valid  = tx_q.size() > 0;
            hif.in_code   = hif.in_valid ? tx_q[0] : '0;
            hif.out_ready = 1'b1;
            cnt_clear     = hif.out_valid;
            #4;
            if (hif.in_valid && hif.in_ready) void'(tx_q.pop_front());
            if (cnt_clear) hit = 1'b1;
        end
        chk("clr_hit", hit, 1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("clr_wins", single_cnt, 0);

        // Random traffic with 0/1/2 bit errors, random stalls and clears
        for (int i = 0; i < 1500; i++) begin
            if (tx_q.size() < 4 && $urandom_range(0, 1) == 0) tx_q.push_back(mk_word($urandom_range(0, 2)));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        drain();

        // Reset with both stages full
        for (int i = 0; i < 3; i++) tx_q.push_back(mk_word(0));
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("full_before_rst", hif.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b0;
        hif.in_valid = 1'b0;
        tx_q.delete();
        #4;
        chk("rst_midstream_ov", hif.out_valid, 0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            chk("post_rst_ov", hif.out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
